// File: rtl/btb_upd_queue_pkg.sv
// btb_upd_queue_pkg: shared types and constants for the BTB retire-update path.
//   btb_upd_t         - one queued retire update {brpc, brdir, tar}, 129 bits
//   BTB_UPD_DEPTH_DEF - default queue depth
//   BR_*              - branch-type encodings used elsewhere in the front end
package btb_upd_queue_pkg;

   localparam int unsigned BTB_UPD_DEPTH_DEF = 4;

   // Branch-type encodings; not decoded by the update queue.
   localparam logic [1:0] BR_COND      = 2'd0;
   localparam logic [1:0] BR_INDIR_RAS = 2'd1;
   localparam logic [1:0] BR_INDIR_PC  = 2'd2;

   typedef struct packed {
      logic [63:0] brpc;
      logic        brdir;
      logic [63:0] tar;
   } btb_upd_t;

endpackage

// File: rtl/btb_upd_queue_if.sv
// btb_upd_queue_if: retire-side inputs and BTB retire-update outputs of btb_upd_queue.
//   rt_valid_i/rt_brpc_i/rt_brdir_i/rt_tar_i - resolved branch from retire
//   btb_sp_we_i                               - fetch1 speculative BTB write (blocks replay)
//   btb_rt_we_o/btb_rt_brdir_o/btb_rt_brpc_o/taken_addr_o - retire update to every BTB way
//   q_empty_o/q_full_o                        - queue occupancy flags
//   drop_cnt_o                                - saturating count of discarded updates
// master: retire/producer side; slave: the queue itself.
interface btb_upd_queue_if #(
   parameter int unsigned CNT_W = 16
);
   logic             rt_valid_i;
   logic [63:0]      rt_brpc_i;
   logic             rt_brdir_i;
   logic [63:0]      rt_tar_i;
   logic             btb_sp_we_i;
   logic             btb_rt_we_o;
   logic             btb_rt_brdir_o;
   logic [63:0]      btb_rt_brpc_o;
   logic [63:0]      taken_addr_o;
   logic             q_empty_o;
   logic             q_full_o;
   logic [CNT_W-1:0] drop_cnt_o;

   modport master (
      output rt_valid_i, rt_brpc_i, rt_brdir_i, rt_tar_i, btb_sp_we_i,
      input  btb_rt_we_o, btb_rt_brdir_o, btb_rt_brpc_o, taken_addr_o,
             q_empty_o, q_full_o, drop_cnt_o
   );

   modport slave (
      input  rt_valid_i, rt_brpc_i, rt_brdir_i, rt_tar_i, btb_sp_we_i,
      output btb_rt_we_o, btb_rt_brdir_o, btb_rt_brpc_o, taken_addr_o,
             q_empty_o, q_full_o, drop_cnt_o
   );
endinterface

// File: rtl/btb_upd_queue_sync_fifo.sv
// sync_fifo: storage, pointers and occupancy for a power-of-two synchronous FIFO.
//   clk, rst    - clock, async active-high reset (discards all entries)
//   push, pop   - write wdata / advance head; caller never pushes when full
//                 without a pop, nor pops when empty
//   wdata       - entry to write
//   rdata       - head entry (raw storage read, undefined when empty)
//   count       - registered occupancy 0..DEPTH
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic [WIDTH-1:0]             wdata,
   output logic [WIDTH-1:0]             rdata,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_d, wr_ptr_q;
   logic [PW-1:0]    rd_ptr_d, rd_ptr_q;
   logic [CW-1:0]    count_d, count_q;

   // Next pointers/occupancy; pointers wrap naturally at DEPTH.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Data array needs no reset: occupancy alone defines which slots are live.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/btb_upd_queue.sv
// btb_upd_queue: buffers resolved branches from retire and replays them, one per
// cycle, onto the BTB retire-update port, yielding to fetch1 speculative writes.
//   clock, reset - clock, async active-high reset (discards queued entries)
//   bus (slave)  - retire inputs, fetch1 write enable, BTB update outputs,
//                  empty/full flags and saturating drop counter
module btb_upd_queue
   import btb_upd_queue_pkg::*;
#(
   parameter int unsigned DEPTH = BTB_UPD_DEPTH_DEF,
   parameter int unsigned CNT_W = 16
) (
   input  logic            clock,
   input  logic            reset,
   btb_upd_queue_if.slave  bus
);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned EW = $bits(btb_upd_t);

   logic [CW-1:0]    count;
   logic             empty;
   logic             full;
   logic             pop;
   logic             push;
   logic             drop;
   btb_upd_t         wr_entry;
   btb_upd_t         head;
   logic [CNT_W-1:0] drop_cnt_d, drop_cnt_q;

   // Replay gating, push acceptance and drop detection. A full queue still
   // accepts a push when the head leaves in the same cycle.
   always_comb begin
      empty          = (count == '0);
      full           = (count == CW'(DEPTH));
      pop            = !empty && !bus.btb_sp_we_i;
      push           = bus.rt_valid_i && (!full || pop);
      drop           = bus.rt_valid_i && full && !pop;
      wr_entry.brpc  = bus.rt_brpc_i;
      wr_entry.brdir = bus.rt_brdir_i;
      wr_entry.tar   = bus.rt_tar_i;
      drop_cnt_d     = drop_cnt_q;
      if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) drop_cnt_q <= '0;
      else       drop_cnt_q <= drop_cnt_d;
   end

   sync_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clock),
      .rst   (reset),
      .push  (push),
      .pop   (pop),
      .wdata (wr_entry),
      .rdata (head),
      .count (count)
   );

   // Head is shown whenever present; all-zero when empty.
   assign bus.btb_rt_we_o    = pop;
   assign bus.btb_rt_brpc_o  = empty ? 64'd0 : head.brpc;
   assign bus.btb_rt_brdir_o = empty ? 1'b0  : head.brdir;
   assign bus.taken_addr_o   = empty ? 64'd0 : head.tar;
   assign bus.q_empty_o      = empty;
   assign bus.q_full_o       = full;
   assign bus.drop_cnt_o     = drop_cnt_q;

endmodule
